// File: rtl/sha256_core_arbiter.sv
// sha256_core_arbiter: round-robin sharing of a single SHA-256 compression core.
// The winning requester's block and chaining input are captured at grant, the
// core is started once, its stale done level is masked for START_HOLD cycles,
// and the result is returned to the requester with a one-cycle valid pulse.
module sha256_core_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int START_HOLD = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*512-1:0] req_msg,
    input  logic [NUM_REQ*256-1:0] req_hin,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [255:0]           rsp_hash,
    output logic                   busy,
    output logic [2:0]             cur_id,
    output logic                   core_start,
    output logic [511:0]           core_message,
    output logic [255:0]           core_in,
    input  logic                   core_done,
    input  logic [255:0]           core_hash
);

    localparam int            HW       = (START_HOLD > 0) ? $clog2(START_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(START_HOLD);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t               state, state_next;
    logic [2:0]           rr, rr_next;
    logic [HW-1:0]        hold_cnt, hold_next;
    logic [NUM_REQ-1:0]   gnt_next, rsp_valid_next;
    logic                 core_start_next, busy_next;
    logic [2:0]           cur_id_next;
    logic [255:0]         rsp_hash_next, hin_next, hin_sel;
    logic [511:0]         msg_next, msg_sel;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 found;
    logic [2:0]           win;
    int                   pos;

    // Round-robin search: rotate req so the pointer sits at bit 0, take the lowest set bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req_rot = NUM_REQ'({req, req} >> rr);
        found   = 1'b0;
        pos     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found = 1'b1;
                pos   = int'(rr) + i;
            end
        end
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        win = 3'(pos);
    end

    // Select the winner's block and chaining input.
    always_comb begin
        msg_sel = '0;
        hin_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == 3'(i)) begin
                msg_sel = req_msg[i*512 +: 512];
                hin_sel = req_hin[i*256 +: 256];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_next      = state;
        rr_next         = rr;
        hold_next       = hold_cnt;
        gnt_next        = '0;
        rsp_valid_next  = '0;
        core_start_next = 1'b0;
        busy_next       = busy;
        cur_id_next     = cur_id;
        rsp_hash_next   = rsp_hash;
        msg_next        = core_message;
        hin_next        = core_in;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_next    = NUM_REQ'(1) << win;
                    cur_id_next = win;
                    busy_next   = 1'b1;
                    msg_next    = msg_sel;
                    hin_next    = hin_sel;
                    state_next  = START;
                end
            end
            START: begin
                core_start_next = 1'b1;
                hold_next       = '0;
                state_next      = WAIT;
            end
            WAIT: begin
                // The core's done is still high from idle right after start; mask it.
                if (hold_cnt != HOLD_MAX) begin
                    hold_next = hold_cnt + 1'b1;
                end else if (core_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_hash_next  = core_hash;
                rsp_valid_next = NUM_REQ'(1) << cur_id;
                busy_next      = 1'b0;
                rr_next        = (cur_id == 3'(NUM_REQ - 1)) ? 3'd0 : cur_id + 3'd1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the wide data registers are plain flops, not memories, so they are cleared with everything else.
        if (!reset_n) begin
            rr           <= '0;
            hold_cnt     <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            cur_id       <= '0;
            rsp_hash     <= '0;
            core_message <= '0;
            core_in      <= '0;
        end else begin
            rr           <= rr_next;
            hold_cnt     <= hold_next;
            gnt          <= gnt_next;
            rsp_valid    <= rsp_valid_next;
            core_start   <= core_start_next;
            busy         <= busy_next;
            cur_id       <= cur_id_next;
            rsp_hash     <= rsp_hash_next;
            core_message <= msg_next;
            core_in      <= hin_next;
        end
    end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// tb_sha256_core_arbiter: directed stimulus with a scoreboard monitor and a
// behavioural SHA-256 compression core standing in for the shared core.
module tb_sha256_core_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int START_HOLD = 3;

    localparam logic [511:0] ABC_MSG  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] IV       = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_HASH = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int           id;
        logic [511:0] msg;
        logic [255:0] hin;
    } gnt_exp_t;

    typedef struct {
        int           id;
        logic [255:0] hash;
    } rsp_exp_t;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [NUM_REQ-1:0]     req = '0;
    logic [NUM_REQ*512-1:0] req_msg = '0;
    logic [NUM_REQ*256-1:0] req_hin = '0;
    logic [NUM_REQ-1:0]     gnt, rsp_valid;
    logic [255:0]           rsp_hash;
    logic                   busy;
    logic [2:0]             cur_id;
    logic                   core_start;
    logic [511:0]           core_message;
    logic [255:0]           core_in;
    logic                   core_done;
    logic [255:0]           core_hash;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    gnt_exp_t exp_gnt [$];
    rsp_exp_t exp_rsp [$];
    int       gnt_cyc_log [$];
    int       start_cyc_log [$];
    int       rsp_cyc_log [$];
    int       last_gnt_cyc = 0;

    logic [511:0] msg_v [NUM_REQ];
    logic [255:0] hin_v [NUM_REQ];

    int       core_lat = 4;
    bit       sticky   = 1'b0;
    int       core_cnt;
    logic [255:0] core_res;

    sha256_core_arbiter #(.NUM_REQ(NUM_REQ), .START_HOLD(START_HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_msg(req_msg), .req_hin(req_hin),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_hash(rsp_hash), .busy(busy), .cur_id(cur_id),
        .core_start(core_start), .core_message(core_message), .core_in(core_in),
        .core_done(core_done), .core_hash(core_hash)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression of one block, including the feed-forward add.
    function automatic logic [255:0] sha_comp(input logic [511:0] m, input logic [255:0] h);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural core: done drops after start (unless sticky) and rises with the result core_lat cycles later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_done <= 1'b1;
            core_hash <= '0;
            core_res  <= '0;
            core_cnt  <= 0;
        end else if (core_start) begin
            if (sticky) begin
                core_hash <= sha_comp(core_message, core_in);
                core_cnt  <= 0;
            end else begin
                core_done <= 1'b0;
                core_res  <= sha_comp(core_message, core_in);
                core_cnt  <= core_lat;
            end
        end else if (core_cnt == 1) begin
            core_done <= 1'b1;
            core_hash <= core_res;
            core_cnt  <= 0;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end
    end

    gnt_exp_t     ge;
    rsp_exp_t     re;
    logic [511:0] cur_msg = '0;
    logic [255:0] cur_hin = '0;

    // Monitor: pops the scoreboard whenever the DUT presents a grant, start or response.
    always @(negedge clk) begin
        if (reset_n) begin
            if (gnt != '0) begin
                gnt_cyc_log.push_back(cyc);
                last_gnt_cyc = cyc;
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", 512'(gnt), 512'(0));
                end else begin
                    ge      = exp_gnt.pop_front();
                    cur_msg = ge.msg;
                    cur_hin = ge.hin;
                    check("gnt_onehot", 512'(gnt), 512'(1 << ge.id));
                    check("gnt_cur_id", 512'(cur_id), 512'(ge.id));
                    check("gnt_busy", 512'(busy), 512'(1));
                    check("gnt_message", core_message, ge.msg);
                    check("gnt_hin", 512'(core_in), 512'(ge.hin));
                end
            end
            if (core_start) begin
                start_cyc_log.push_back(cyc);
                check("start_latency", 512'(cyc - last_gnt_cyc), 512'(1));
                check("start_message", core_message, cur_msg);
                check("start_hin", 512'(core_in), 512'(cur_hin));
            end
            if (rsp_valid != '0) begin
                rsp_cyc_log.push_back(cyc);
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 512'(rsp_valid), 512'(0));
                end else begin
                    re = exp_rsp.pop_front();
                    check("rsp_onehot", 512'(rsp_valid), 512'(1 << re.id));
                    check("rsp_hash", 512'(rsp_hash), 512'(re.hash));
                    check("rsp_busy_low", 512'(busy), 512'(0));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) req[i] = 1'b0;
    endtask

    task automatic expect_job(input int i, input logic [255:0] hash);
        gnt_exp_t g;
        rsp_exp_t r;
        g.id = i; g.msg = msg_v[i]; g.hin = hin_v[i];
        r.id = i; r.hash = hash;
        exp_gnt.push_back(g);
        exp_rsp.push_back(r);
    endtask

    task automatic expect_ref(input int i);
        expect_job(i, sha_comp(msg_v[i], hin_v[i]));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((req != '0 || busy || exp_gnt.size() != 0 || exp_rsp.size() != 0) && n < budget);
        check(name, 512'({req != '0, busy, exp_gnt.size() != 0, exp_rsp.size() != 0}), 512'(0));
    endtask

    task automatic wait_gnt(input int count, input int budget);
        int n = 0;
        while (gnt_cyc_log.size() < count && n < budget) begin
            step();
            n++;
        end
        check("gnt_arrival", 512'(gnt_cyc_log.size() >= count), 512'(1));
    endtask

    task automatic clear_logs();
        gnt_cyc_log.delete();
        start_cyc_log.delete();
        rsp_cyc_log.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 512'(gnt), 512'(0));
        check({tag, "_rsp_valid"}, 512'(rsp_valid), 512'(0));
        check({tag, "_core_start"}, 512'(core_start), 512'(0));
        check({tag, "_busy"}, 512'(busy), 512'(0));
        check({tag, "_cur_id"}, 512'(cur_id), 512'(0));
        check({tag, "_rsp_hash"}, 512'(rsp_hash), 512'(0));
        check({tag, "_core_message"}, core_message, 512'(0));
        check({tag, "_core_in"}, 512'(core_in), 512'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        msg_v[0] = ABC_MSG;
        hin_v[0] = IV;
        for (int i = 1; i < NUM_REQ; i++) begin
            msg_v[i] = ABC_MSG ^ (512'(i * 32'h1357) << 200);
            hin_v[i] = IV + 256'(i * 7);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_msg[i*512 +: 512] = msg_v[i];
            req_hin[i*256 +: 256] = hin_v[i];
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) step();

        // Single "abc" job on requester 0 with a known digest.
        clear_logs();
        req[0] = 1'b1;
        expect_job(0, ABC_HASH);
        wait_idle("abc_idle", 60);
        check("abc_starts", 512'(start_cyc_log.size()), 512'(1));
        check("abc_latency", 512'(rsp_cyc_log[0] - gnt_cyc_log[0]), 512'(core_lat + 4));

        // All four requests from reset: strict rotation, then wrap back to 0 ahead of 3.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        clear_logs();
        req = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) expect_ref(i);
        wait_idle("all4_idle", 200);
        check("all4_grants", 512'(gnt_cyc_log.size()), 512'(4));
        for (int k = 0; k < 3; k++) check("all4_b2b_gap", 512'(gnt_cyc_log[k+1] - rsp_cyc_log[k]), 512'(1));
        req[0] = 1'b1;
        req[3] = 1'b1;
        expect_ref(0);
        expect_ref(3);
        wait_idle("wrap_idle", 100);

        // Request arriving during WAIT waits for the current job to respond.
        clear_logs();
        req[0] = 1'b1;
        expect_ref(0);
        expect_ref(2);
        wait_gnt(1, 20);
        repeat (3) step();
        req[2] = 1'b1;
        wait_idle("late_idle", 100);
        check("late_starts", 512'(start_cyc_log.size()), 512'(2));
        check("late_gap", 512'(gnt_cyc_log[1] - rsp_cyc_log[0]), 512'(1));

        // Core done stuck high: the hold window sets the earliest response.
        clear_logs();
        sticky = 1'b1;
        req[1] = 1'b1;
        expect_ref(1);
        wait_idle("sticky_idle", 60);
        check("sticky_latency", 512'(rsp_cyc_log[0] - start_cyc_log[0]), 512'(START_HOLD + 2));
        sticky = 1'b0;

        // Request data corrupted after grant has no effect on the job in flight.
        clear_logs();
        req[2] = 1'b1;
        expect_ref(2);
        wait_gnt(1, 20);
        req_msg[2*512 +: 512] = ~msg_v[2];
        req_hin[2*256 +: 256] = ~hin_v[2];
        wait_idle("corrupt_idle", 60);
        req_msg[2*512 +: 512] = msg_v[2];
        req_hin[2*256 +: 256] = hin_v[2];

        // Reset in WAIT discards the job, then the pointer restarts at 0.
        clear_logs();
        req[3] = 1'b1;
        expect_ref(3);
        wait_gnt(1, 20);
        repeat (2) step();
        reset_n = 1'b0;
        void'(exp_rsp.pop_back());
        #1;
        check_all_zero("midreset");
        repeat (2) step();
        reset_n = 1'b1;
        repeat (12) step();
        check("midreset_no_rsp", 512'(rsp_cyc_log.size()), 512'(0));
        req[1] = 1'b1;
        req[3] = 1'b1;
        expect_ref(1);
        expect_ref(3);
        wait_idle("post_reset_idle", 100);

        check("queues_drained", 512'(exp_gnt.size() + exp_rsp.size()), 512'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
